// File: rtl/accum_warp_addr_arbiter_pkg.sv
// Shared types and default geometry for the accumulator warp address arbiter.
// Defaults stand in for the tile accumulator configuration (config count, address width, lanes).
package accum_warp_addr_arbiter_pkg;

  localparam int unsigned DEF_N_CFG = 4;
  localparam int unsigned DEF_ABW   = 16;
  localparam int unsigned DEF_VSIZE = 4;

  typedef enum logic {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/accum_warp_addr_arbiter_picker.sv
// Round-robin picker: first set mask bit at or after ptr, wrapping modulo N.
// Purely combinational so it can be reused by other arbiters.
module accum_warp_addr_arbiter_picker #(
  parameter int unsigned N = 2,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  i_mask,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_oh,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  int unsigned pos;
  int unsigned j;

  always_comb begin
    o_oh  = '0;
    o_idx = '0;
    o_any = 1'b0;
    pos   = 0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(i_ptr) + k;
      j   = pos % N;
      if (!o_any && i_mask[j]) begin
        o_any   = 1'b1;
        o_oh[j] = 1'b1;
        o_idx   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/accum_warp_addr_arbiter.sv
// Shares one vector-address request port among N_REQ looper streams with round-robin
// grant, optional lock until a retire beat, and a registered output tagged by requester.
module accum_warp_addr_arbiter
  import accum_warp_addr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned N_CFG = DEF_N_CFG,
  parameter int unsigned ABW   = DEF_ABW,
  parameter int unsigned VSIZE = DEF_VSIZE,
  parameter bit          HOLD  = 1'b1,
  localparam int unsigned NCFG_BW = $clog2(N_CFG + 1),
  localparam int unsigned REQ_BW  = $clog2(N_REQ)
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [N_REQ-1:0]                       src_rdys,
  output logic [N_REQ-1:0]                       src_acks,
  input  logic [N_REQ-1:0][NCFG_BW-1:0]          i_ids,
  input  logic [N_REQ-1:0][VSIZE-1:0][ABW-1:0]   i_addresses,
  input  logic [N_REQ-1:0][VSIZE-1:0]            i_valids,
  input  logic [N_REQ-1:0]                       i_retires,
  output logic                                   dst_rdy,
  input  logic                                   dst_ack,
  output logic [REQ_BW-1:0]                      o_req,
  output logic [NCFG_BW-1:0]                     o_id,
  output logic [VSIZE-1:0][ABW-1:0]              o_address,
  output logic [VSIZE-1:0]                       o_valid,
  output logic                                   o_retire,
  output logic                                   o_busy
);

  lock_state_e       state_q, state_d;
  logic [REQ_BW-1:0] owner_q, owner_d;
  logic [REQ_BW-1:0] ptr_q, ptr_d;

  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  pick_oh;
  logic [REQ_BW-1:0] pick_idx;
  logic              pick_any;
  logic              can_take;
  logic              accept;

  // While locked only the owner may compete; others see a bubble.
  always_comb begin
    elig = src_rdys;
    if (state_q == LK_LOCKED) begin
      elig = src_rdys & (N_REQ'(1) << owner_q);
    end
  end

  accum_warp_addr_arbiter_picker #(.N(N_REQ)) u_picker (
    .i_mask (elig),
    .i_ptr  (ptr_q),
    .o_oh   (pick_oh),
    .o_idx  (pick_idx),
    .o_any  (pick_any)
  );

  // A new beat may enter in the same cycle the held one leaves.
  assign can_take = !dst_rdy || dst_ack;
  assign accept   = can_take && pick_any && !i_rst;
  assign src_acks = accept ? pick_oh : '0;
  assign o_busy   = dst_rdy || (state_q == LK_LOCKED);

  // Lock FSM next state and pointer advance.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (accept) begin
      ptr_d = (32'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + REQ_BW'(1);
      if (HOLD) begin
        case (state_q)
          LK_IDLE: begin
            if (!i_retires[pick_idx]) begin
              state_d = LK_LOCKED;
              owner_d = pick_idx;
            end
          end
          LK_LOCKED: begin
            if (i_retires[pick_idx]) begin
              state_d = LK_IDLE;
            end
          end
          default: state_d = LK_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= LK_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Output beat register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dst_rdy   <= 1'b0;
      o_req     <= '0;
      o_id      <= '0;
      o_address <= '0;
      o_valid   <= '0;
      o_retire  <= 1'b0;
    end else if (accept) begin
      dst_rdy   <= 1'b1;
      o_req     <= pick_idx;
      o_id      <= i_ids[pick_idx];
      o_address <= i_addresses[pick_idx];
      o_valid   <= i_valids[pick_idx];
      o_retire  <= i_retires[pick_idx];
    end else if (dst_ack) begin
      dst_rdy   <= 1'b0;
    end
  end

endmodule
